// File: rtl/hex_ascii_serializer.sv
// hex_ascii_serializer
//   Streaming converter from binary words to ASCII hex text. One word of
//   NIBBLES*4 bits is accepted per valid/ready handshake and printed most
//   significant nibble first, one ASCII character per handshake, with an
//   optional CR LF terminator. Intended to feed a byte-wide UART transmitter.
//
// Parameters
//   NIBBLES        hex digits per word (1..16)
//   UPPERCASE      1: A-F as 8'h41..8'h46, 0: a-f as 8'h61..8'h66
//   ADD_CRLF       1: append 8'h0D 8'h0A after the last digit
//   SUPPRESS_ZEROS 1: drop leading zero digits, always print at least one
//
// Ports
//   clk         rising-edge clock
//   nrst        asynchronous active-low reset
//   word_data   word to print
//   word_valid  word_data valid
//   word_ready  serializer can accept a word (IDLE only)
//   char_data   ASCII character
//   char_valid  char_data valid
//   char_ready  downstream accepts char_data
//   busy        a word is in progress
module hex_ascii_serializer #(
    parameter int NIBBLES        = 8,
    parameter bit UPPERCASE      = 1'b1,
    parameter bit ADD_CRLF       = 1'b1,
    parameter bit SUPPRESS_ZEROS = 1'b0
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [NIBBLES*4-1:0] word_data,
    input  logic                 word_valid,
    output logic                 word_ready,
    output logic [7:0]           char_data,
    output logic                 char_valid,
    input  logic                 char_ready,
    output logic                 busy
);

    localparam int W  = NIBBLES * 4;
    localparam int CW = 4;  // digit index 0..15 covers every legal NIBBLES

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIGITS,
        S_CR,
        S_LF
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    shreg;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   lead_idx;
    logic [CW-1:0]   lead_gap;
    logic [W-1:0]    aligned;

    // ASCII for one hex digit; 8'h37 + 10 = 'A', 8'h57 + 10 = 'a'.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, n};
    endfunction

    // Index of the first digit to print. With suppression this is the
    // highest nonzero nibble (0 for an all-zero word, so one '0' is printed).
    always_comb begin
        lead_idx = CW'(NIBBLES - 1);
        if (SUPPRESS_ZEROS) begin
            lead_idx = '0;
            for (int i = 0; i < NIBBLES; i++) begin
                if (word_data[i*4 +: 4] != 4'h0) begin
                    lead_idx = CW'(i);
                end
            end
        end
    end

    // Pre-align so the first printed digit sits in the top nibble; the
    // emit path then only ever looks at shreg[W-1 -: 4].
    assign lead_gap = CW'(NIBBLES - 1) - lead_idx;
    assign aligned  = word_data << {lead_gap, 2'b00};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_nxt  = state;
        word_ready = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        unique case (state)
            S_IDLE: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    state_nxt = S_DIGITS;
                end
            end
            S_DIGITS: begin
                char_valid = 1'b1;
                char_data  = hex_char(shreg[W-1 -: 4]);
                if (char_ready && cnt == '0) begin
                    state_nxt = ADD_CRLF ? S_CR : S_IDLE;
                end
            end
            S_CR: begin
                char_valid = 1'b1;
                char_data  = 8'h0D;
                if (char_ready) begin
                    state_nxt = S_LF;
                end
            end
            S_LF: begin
                char_valid = 1'b1;
                char_data  = 8'h0A;
                if (char_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load on accept, advance one digit per transfer. On the last
    // digit the register is left alone; the next accept reloads it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (state == S_IDLE && word_valid) begin
            shreg <= aligned;
            cnt   <= lead_idx;
        end else if (state == S_DIGITS && char_ready && cnt != '0) begin
            shreg <= shreg << 4;
            cnt   <= cnt - 1'b1;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_hex_ascii_serializer.sv
// Self-checking bench for hex_ascii_serializer. Four instances cover the
// parameter variants (default, lowercase, zero suppression, no CR LF); each
// word's expected character stream comes from a digit-by-digit model.
module tb_hex_ascii_serializer;

    localparam bit CFG_UPPER [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    localparam bit CFG_CRLF  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    localparam bit CFG_SUPP  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic        clk;
    logic        nrst;
    logic [31:0] wd   [4];
    logic        wv   [4];
    logic        wr   [4];
    logic [7:0]  cd   [4];
    logic        cv   [4];
    logic        cr   [4];
    logic        bsy  [4];

    int n_checks;
    int n_fail;
    logic [7:0] exp_q [$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        hex_ascii_serializer #(
            .NIBBLES        (8),
            .UPPERCASE      (CFG_UPPER[g]),
            .ADD_CRLF       (CFG_CRLF[g]),
            .SUPPRESS_ZEROS (CFG_SUPP[g])
        ) u_dut (
            .clk        (clk),
            .nrst       (nrst),
            .word_data  (wd[g]),
            .word_valid (wv[g]),
            .word_ready (wr[g]),
            .char_data  (cd[g]),
            .char_valid (cv[g]),
            .char_ready (cr[g]),
            .busy       (bsy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected characters for word w on instance k, built digit by digit.
    task automatic model(input int k, input logic [31:0] w);
        bit started;
        int d;
        exp_q.delete();
        started = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            d = int'((w >> (4 * i)) & 32'hF);
            if (CFG_SUPP[k] && !started && d == 0 && i != 0) continue;
            started = 1'b1;
            if (d < 10) exp_q.push_back(8'(8'h30 + d));
            else        exp_q.push_back(8'((CFG_UPPER[k] ? 8'h41 : 8'h61) + d - 10));
        end
        if (CFG_CRLF[k]) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    // Called and returns at a falling edge. Presents w, checks first-char
    // latency, drains the stream with char_ready high pct% of cycles, and
    // checks hold-under-stall and the idle cycle after the final transfer.
    // After accept, word_data/word_valid are set to nxt_w/nxt_v.
    task automatic run_word(input int k, input logic [31:0] w, input int pct,
                            input logic [31:0] nxt_w, input logic nxt_v, input string tag);
        logic [7:0] got_q [$];
        logic [7:0] last_c;
        bit         stalled;
        bit         rdy;
        int         cyc;
        model(k, w);
        wd[k] = w;
        wv[k] = 1'b1;
        check({tag, "_ready_idle"}, 32'(wr[k]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        wd[k] = nxt_v ? nxt_w : $urandom;
        wv[k] = nxt_v;
        check({tag, "_first_valid"}, 32'(cv[k]), 32'd1);
        stalled = 1'b0;
        last_c  = 8'h00;
        cyc     = 0;
        while (got_q.size() < exp_q.size() && cyc < 400) begin
            if (!cv[k]) begin
                check({tag, "_valid_dropped"}, 32'(cv[k]), 32'd1);
                break;
            end
            if (stalled) check({tag, "_stall_hold"}, 32'(cd[k]), 32'(last_c));
            check({tag, "_ready_busy"}, 32'(wr[k]), 32'd0);
            rdy   = ($urandom_range(99) < pct);
            cr[k] = rdy;
            if (rdy) got_q.push_back(cd[k]);
            stalled = !rdy;
            last_c  = cd[k];
            @(negedge clk);
            cyc++;
        end
        cr[k] = 1'b0;
        if (pct >= 100) check({tag, "_cycles"}, 32'(cyc), 32'(exp_q.size()));
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_char%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check({tag, "_end_ready"}, 32'(wr[k]), 32'd1);
        check({tag, "_end_valid"}, 32'(cv[k]), 32'd0);
        check({tag, "_end_busy"},  32'(bsy[k]), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        n_checks = 0;
        n_fail   = 0;
        nrst     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wd[k] = '0;
            wv[k] = 1'b0;
            cr[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_ready%0d", k), 32'(wr[k]), 32'd1);
            check($sformatf("rst_valid%0d", k), 32'(cv[k]), 32'd0);
            check($sformatf("rst_data%0d", k),  32'(cd[k]), 32'd0);
            check($sformatf("rst_busy%0d", k),  32'(bsy[k]), 32'd0);
        end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_word(0, 32'hDEADBEEF, 100, 0, 1'b0, "upper");
        run_word(1, 32'hDEADBEEF, 100, 0, 1'b0, "lower");
        run_word(0, 32'h0123ABCD, 30,  0, 1'b0, "bp");
        run_word(2, 32'h000000A0, 100, 0, 1'b0, "sz_a0");
        run_word(2, 32'h00000000, 100, 0, 1'b0, "sz_zero");
        run_word(2, 32'h80000000, 100, 0, 1'b0, "sz_msb");
        run_word(3, 32'h11111111, 100, 32'h22222222, 1'b1, "b2b1");
        run_word(3, 32'h22222222, 100, 0, 1'b0, "b2b2");

        // Mid-word reset on the default instance after three digits.
        wd[0] = 32'hDEADBEEF;
        wv[0] = 1'b1;
        cr[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wv[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before", 32'(bsy[0]), 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(cv[0]), 32'd0);
        check("mid_rst_busy",  32'(bsy[0]), 32'd0);
        check("mid_rst_ready", 32'(wr[0]), 32'd1);
        cr[0] = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("mid_idle_valid", 32'(cv[0]), 32'd0);
        run_word(0, 32'h00000001, 100, 0, 1'b0, "post_rst");

        // Randomized words and backpressure on every variant.
        for (int n = 0; n < 24; n++) begin
            int k;
            k = n % 4;
            w = $urandom;
            if ($urandom_range(1)) w = w >> $urandom_range(31);
            run_word(k, w, $urandom_range(100, 20), 0, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
